// File: rtl/fyra_pkg.sv
// Shared core types: fetch entry bundle, NOP encoding and base opcodes.
// Shared with decode/signExt.
package fyra_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: DEPTH x fetch_entry_t, one write port, async read.
// Data array is deliberately not reset.
module fetch_queue_mem
  import fyra_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         wr_en,
  input  logic [PW-1:0] wr_ptr,
  input  fetch_entry_t wr_data,
  input  logic [PW-1:0] rd_ptr,
  output fetch_entry_t rd_data
);

  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between IMEM and decode; flushed on redirect.
// FETCHQ_BYPASS_EN: zero-latency path from in_* to out_* while empty.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [31:0]                in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_inst,
  output logic [6:0]                 out_opcode,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  import fyra_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CFULL = CW'(DEPTH);

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  fetch_entry_t  head, wdata;
  logic          empty, byp, push, pop, wr, rd;

  assign empty    = (cnt == '0);
  assign in_ready = (cnt != CFULL) & ~flush;

`ifdef FETCHQ_BYPASS_EN
  assign byp = empty & in_valid & ~flush;
`else
  assign byp = 1'b0;
`endif

  assign out_valid = ~empty | byp;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // a bypassed entry taken by decode never touches storage
  assign wr        = push & ~(byp & out_ready);
  assign rd        = pop & ~empty;

  assign wdata.pc   = in_pc;
  assign wdata.inst = in_inst;

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr),
    .wr_ptr  (wr_ptr),
    .wr_data (wdata),
    .rd_ptr  (rd_ptr),
    .rd_data (head)
  );

  always_ff @(posedge clk) begin
    if (rst | flush) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PW'(1);
      if (rd) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(wr) - CW'(rd);
    end
  end

  always_comb begin
    out_pc   = '0;
    out_inst = NOP_INST;
    if (!empty) begin
      out_pc   = head.pc;
      out_inst = head.inst;
    end else if (byp) begin
      out_pc   = in_pc;
      out_inst = in_inst;
    end
  end

  assign out_opcode = out_inst[6:0];
  assign count      = cnt;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized + directed bench for fetch_queue against a queue-based model.
// Honors FETCHQ_BYPASS_EN the same way the design does.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;
  logic [6:0]  out_opcode;
  logic [2:0]  count;

  int n_chk = 0;
  int n_pass = 0;

  logic [63:0] q[$];
  bit          known = 0;

  logic        s_valid, s_ready;
  logic [31:0] s_pc, s_inst;
  logic [6:0]  s_op;
  logic [2:0]  s_cnt;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst),
    .out_opcode(out_opcode), .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  task automatic cycle(input logic iv, input logic [31:0] ipc,
                       input logic [31:0] ii, input logic ordy,
                       input logic fl, input logic r);
    logic        ir, byp, ev, push, pop;
    logic [31:0] epc, ei;
    rst = r; flush = fl; in_valid = iv;
    in_pc = ipc; in_inst = ii; out_ready = ordy;
    @(negedge clk);
    s_valid = out_valid; s_ready = in_ready; s_pc = out_pc;
    s_inst = out_inst; s_op = out_opcode; s_cnt = count;
    ir  = (q.size() < DEPTH) && !fl;
    byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    byp = (q.size() == 0) && iv && !fl;
`endif
    ev = (q.size() != 0) || byp;
    if (q.size() != 0) {epc, ei} = q[0];
    else if (byp) begin epc = ipc; ei = ii; end
    else begin epc = '0; ei = NOP; end
    if (known && !r) begin
      chk("count", 64'(s_cnt), 64'(q.size()));
      chk("in_ready", 64'(s_ready), 64'(ir));
      chk("out_valid", 64'(s_valid), 64'(ev));
      chk("out_pc", 64'(s_pc), 64'(epc));
      chk("out_inst", 64'(s_inst), 64'(ei));
      chk("out_opcode", 64'(s_op), 64'(ei[6:0]));
    end
    push = iv && ir;
    pop  = ev && ordy;
    @(posedge clk);
    if (r || fl) q.delete();
    else begin
      if (pop && q.size() != 0) void'(q.pop_front());
      if (push && !(byp && pop)) q.push_back({ipc, ii});
    end
    if (r) known = 1;
    #1;
  endtask

  logic [31:0] insts [4];
  logic [6:0]  opcs  [4];
  logic [31:0] last_pc, npc;
  bit          seen;

  initial begin
    insts[0] = 32'h01190933; opcs[0] = 7'b0110011;
    insts[1] = 32'hfffb8b93; opcs[1] = 7'b0010011;
    insts[2] = 32'h0082a223; opcs[2] = 7'b0100011;
    insts[3] = 32'h014c6463; opcs[3] = 7'b1100011;
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    in_pc = 0; in_inst = 0;
    @(posedge clk); #1;

    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("rst_inst", 64'(s_inst), 64'(NOP));
    chk("rst_ready", 64'(s_ready), 64'd1);

    for (int i = 0; i < 4; i++) cycle(1, 32'(i * 4), insts[i], 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("full_cnt", 64'(s_cnt), 64'd4);
    chk("full_rdy", 64'(s_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1, 0, 0);
      chk("drain_pc", 64'(s_pc), 64'(i * 4));
      chk("drain_op", 64'(s_op), 64'(opcs[i]));
    end

    for (int i = 0; i < 4; i++) cycle(1, 32'h40 + 32'(i * 4), 32'h13, 0, 0, 0);
    cycle(1, 32'h50, 32'h33, 1, 0, 0);
    chk("fpp_rdy", 64'(s_ready), 64'd0);
    cycle(1, 32'h50, 32'h33, 0, 0, 0);
    chk("fpp_cnt3", 64'(s_cnt), 64'd3);
    cycle(0, 0, 0, 0, 0, 0);
    chk("fpp_cnt4", 64'(s_cnt), 64'd4);

    cycle(0, 0, 0, 0, 1, 0);
    cycle(1, 32'h200, 32'h13, 0, 0, 0);
    cycle(1, 32'h204, 32'h13, 0, 0, 0);
    npc = 32'h208; seen = 0; last_pc = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, npc, 32'h00000033, 1, 0, 0);
      chk("strm_cnt", 64'(s_cnt), 64'd2);
      if (seen) chk("strm_mono", 64'(s_pc), 64'(last_pc + 4));
      last_pc = s_pc; seen = 1;
      npc += 4;
    end

    cycle(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 32'h300 + 32'(i * 4), 32'h13, 0, 0, 0);
    cycle(1, 32'h3f0, 32'h13, 1, 1, 0);
    cycle(1, 32'h100, 32'h7ff080e7, 0, 0, 0);
    chk("fl_cnt0", 64'(s_cnt), 64'd0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("fl_head", 64'(s_pc), 64'h100);
    chk("fl_hinst", 64'(s_inst), 64'h7ff080e7);

    cycle(0, 0, 0, 0, 1, 0);
    cycle(1, 32'h400, 32'h0000006f, 1, 0, 0);
`ifdef FETCHQ_BYPASS_EN
    chk("byp_valid", 64'(s_valid), 64'd1);
    chk("byp_op", 64'(s_op), 64'(7'b1101111));
`else
    chk("nobyp_valid", 64'(s_valid), 64'd0);
`endif
    cycle(0, 0, 0, 0, 0, 0);
`ifdef FETCHQ_BYPASS_EN
    chk("byp_cnt", 64'(s_cnt), 64'd0);
`else
    chk("nobyp_late", 64'(s_valid), 64'd1);
`endif

    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            32'($urandom) & ~32'h3, 32'($urandom),
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 59) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
